// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Drives the RESETB/BYPASS pins of an SB_PLL40_CORE and supervises its LOCK
//   output. At power-up the PLL is held in reset, then lock is awaited with a
//   timeout and a bounded number of retries. Lock must stay continuously
//   present for STABLE_CYCLES before downstream logic leaves reset. While
//   running, loss of lock re-enters the full reset/relock sequence. Lives in
//   the reference clock domain.
//
// Ports
//   clk          reference clock (also the PLL reference input)
//   rst          asynchronous active-high reset
//   pll_lock     PLL LOCK, asynchronous, synchronized internally
//   pll_resetb   PLL RESETB, active low
//   pll_bypass   PLL BYPASS
//   sys_rst      active-high reset for downstream logic
//   ready        high only in RUN
//   fail         high only in FAIL
//   lock_lost    sticky flag: lock dropped while in RUN
//   retry_count  lock attempts consumed after the first one
//   state        current FSM state, for debug/LEDs
module pll_reset_sequencer #(
  parameter int RESET_CYCLES   = 16,
  parameter int LOCK_TIMEOUT   = 4096,
  parameter int STABLE_CYCLES  = 256,
  parameter int MAX_RETRIES    = 3,
  parameter bit BYPASS_ON_FAIL = 1'b1,
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pll_lock,
  output logic          pll_resetb,
  output logic          pll_bypass,
  output logic          sys_rst,
  output logic          ready,
  output logic          fail,
  output logic          lock_lost,
  output logic [RW-1:0] retry_count,
  output logic [2:0]    state
);

  localparam int MAX_AB  = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] RESET_LAST   = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  state_t        state_q, next_state;
  logic [CW-1:0] counter_q, counter_d;
  logic [RW-1:0] retry_d;
  logic          lost_d;
  logic [1:0]    lock_sync;
  logic          lock_s;
  logic          resetb_d, bypass_d, sys_rst_d, ready_d, fail_d;

  assign lock_s = lock_sync[1];
  assign state  = state_q;

  // State register. The pin outputs are registered from next-state decode so
  // they change on the same edge as the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PLL_RESET;
      counter_q   <= '0;
      retry_count <= '0;
      lock_lost   <= 1'b0;
      lock_sync   <= 2'b00;
      pll_resetb  <= 1'b0;
      pll_bypass  <= 1'b0;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state_q     <= next_state;
      counter_q   <= counter_d;
      retry_count <= retry_d;
      lock_lost   <= lost_d;
      lock_sync   <= {lock_sync[0], pll_lock};
      pll_resetb  <= resetb_d;
      pll_bypass  <= bypass_d;
      sys_rst     <= sys_rst_d;
      ready       <= ready_d;
      fail        <= fail_d;
    end
  end

  // Next-state logic. The cycle counter is cleared on every transition and
  // never counts in RUN/FAIL, so it cannot wrap.
  always_comb begin
    next_state = state_q;
    counter_d  = counter_q;
    retry_d    = retry_count;
    lost_d     = lock_lost;
    case (state_q)
      PLL_RESET: begin
        if (counter_q == RESET_LAST) begin
          next_state = WAIT_LOCK;
          counter_d  = '0;
        end else begin
          counter_d = counter_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          next_state = STABLE;
          counter_d  = '0;
        end else if (counter_q == TIMEOUT_LAST) begin
          counter_d = '0;
          if (retry_count == RETRY_MAX) begin
            next_state = FAIL;
          end else begin
            next_state = PLL_RESET;
            retry_d    = retry_count + 1'b1;
          end
        end else begin
          counter_d = counter_q + 1'b1;
        end
      end
      STABLE: begin
        // A lock glitch here restarts the wait without spending a retry.
        if (!lock_s) begin
          next_state = WAIT_LOCK;
          counter_d  = '0;
        end else if (counter_q == STABLE_LAST) begin
          next_state = RUN;
          counter_d  = '0;
        end else begin
          counter_d = counter_q + 1'b1;
        end
      end
      RUN: begin
        // Loss of lock starts a fresh sequence with a full retry budget.
        if (!lock_s) begin
          next_state = PLL_RESET;
          counter_d  = '0;
          retry_d    = '0;
          lost_d     = 1'b1;
        end
      end
      FAIL: begin
        counter_d = '0;
      end
      default: begin
        // Illegal encodings recover exactly as if rst had been applied.
        next_state = PLL_RESET;
        counter_d  = '0;
        retry_d    = '0;
        lost_d     = 1'b0;
      end
    endcase
  end

  // Output decode of the next state, fed into the output registers above.
  always_comb begin
    resetb_d  = 1'b0;
    bypass_d  = 1'b0;
    sys_rst_d = 1'b1;
    ready_d   = 1'b0;
    fail_d    = 1'b0;
    case (next_state)
      WAIT_LOCK, STABLE: begin
        resetb_d = 1'b1;
      end
      RUN: begin
        resetb_d  = 1'b1;
        sys_rst_d = 1'b0;
        ready_d   = 1'b1;
      end
      FAIL: begin
        fail_d    = 1'b1;
        bypass_d  = BYPASS_ON_FAIL;
        sys_rst_d = ~BYPASS_ON_FAIL;
      end
      default: begin
        resetb_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
//   Directed bench for pll_reset_sequencer with default parameters. The
//   stimulus process queues every FSM transition it expects (edge number,
//   state, pin values); a monitor pops and compares whenever the DUT state
//   changes. A second instance with BYPASS_ON_FAIL=0 and lock tied low runs
//   alongside and is checked in its terminal FAIL state.
module tb_pll_reset_sequencer;

  localparam int RESET_CYCLES  = 16;
  localparam int LOCK_TIMEOUT  = 4096;
  localparam int STABLE_CYCLES = 256;
  localparam int ATTEMPT       = RESET_CYCLES + LOCK_TIMEOUT;
  localparam int RELEASE       = STABLE_CYCLES + 3;

  localparam int S_RST  = 0;
  localparam int S_WAIT = 1;
  localparam int S_STAB = 2;
  localparam int S_RUN  = 3;
  localparam int S_FAIL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rst2 = 1'b0;
  logic       pll_lock = 1'b0;
  logic       pll_resetb, pll_bypass, sys_rst, ready, fail, lock_lost;
  logic [1:0] retry_count;
  logic [2:0] state;
  logic       pll_resetb2, pll_bypass2, sys_rst2, ready2, fail2, lock_lost2;
  logic [1:0] retry_count2;
  logic [2:0] state2;

  pll_reset_sequencer dut (
    .clk(clk), .rst(rst), .pll_lock(pll_lock),
    .pll_resetb(pll_resetb), .pll_bypass(pll_bypass), .sys_rst(sys_rst),
    .ready(ready), .fail(fail), .lock_lost(lock_lost),
    .retry_count(retry_count), .state(state)
  );

  pll_reset_sequencer #(.BYPASS_ON_FAIL(1'b0)) dut_nobypass (
    .clk(clk), .rst(rst2), .pll_lock(1'b0),
    .pll_resetb(pll_resetb2), .pll_bypass(pll_bypass2), .sys_rst(sys_rst2),
    .ready(ready2), .fail(fail2), .lock_lost(lock_lost2),
    .retry_count(retry_count2), .state(state2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    int c; int st; int resetb; int bypass; int srst;
    int rdy; int fl; int lost; int retry;
  } ev_t;

  ev_t sb[$];
  ev_t mon_ev;
  int  ev_idx = 0;
  logic [2:0] prev_state = 3'd0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Pin values per state for BYPASS_ON_FAIL=1.
  task automatic expectEvent(input int c, input int st, input int lost, input int retry);
    ev_t e;
    e.c = c; e.st = st; e.lost = lost; e.retry = retry;
    e.resetb = (st == S_WAIT || st == S_STAB || st == S_RUN) ? 1 : 0;
    e.bypass = (st == S_FAIL) ? 1 : 0;
    e.srst   = (st == S_RUN || st == S_FAIL) ? 0 : 1;
    e.rdy    = (st == S_RUN) ? 1 : 0;
    e.fl     = (st == S_FAIL) ? 1 : 0;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic lock, input logic r);
    pll_lock = lock;
    rst      = r;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_state"},  int'(state), S_RST);
    checkOutput({tag, "_resetb"}, int'(pll_resetb), 0);
    checkOutput({tag, "_bypass"}, int'(pll_bypass), 0);
    checkOutput({tag, "_sysrst"}, int'(sys_rst), 1);
    checkOutput({tag, "_ready"},  int'(ready), 0);
    checkOutput({tag, "_fail"},   int'(fail), 0);
    checkOutput({tag, "_lost"},   int'(lock_lost), 0);
    checkOutput({tag, "_retry"},  int'(retry_count), 0);
  endtask

  // Monitor: every state change must match the next queued transition.
  always @(negedge clk) begin
    if (state != prev_state) begin
      prev_state = state;
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_transition: got state %0d at edge %0d, expected none", state, cyc);
      end else begin
        mon_ev = sb.pop_front();
        checkOutput($sformatf("ev%0d_edge", ev_idx),   cyc, mon_ev.c);
        checkOutput($sformatf("ev%0d_state", ev_idx),  int'(state), mon_ev.st);
        checkOutput($sformatf("ev%0d_resetb", ev_idx), int'(pll_resetb), mon_ev.resetb);
        checkOutput($sformatf("ev%0d_bypass", ev_idx), int'(pll_bypass), mon_ev.bypass);
        checkOutput($sformatf("ev%0d_sysrst", ev_idx), int'(sys_rst), mon_ev.srst);
        checkOutput($sformatf("ev%0d_ready", ev_idx),  int'(ready), mon_ev.rdy);
        checkOutput($sformatf("ev%0d_fail", ev_idx),   int'(fail), mon_ev.fl);
        checkOutput($sformatf("ev%0d_lost", ev_idx),   int'(lock_lost), mon_ev.lost);
        checkOutput($sformatf("ev%0d_retry", ev_idx),  int'(retry_count), mon_ev.retry);
        ev_idx++;
      end
    end
  end

  initial begin
    int b, n, m, p, g, q, b2, b3, l, b4, b5;

    #1 rst = 1'b1; rst2 = 1'b1;
    #1 checkResetOutputs("por");
    step(2);
    b = cyc;
    rst2 = 1'b0;
    applyStimulus(1'b0, 1'b0);

    // Lock rises 100 cycles after pll_resetb; release 259 edges later.
    expectEvent(b + RESET_CYCLES, S_WAIT, 0, 0);
    step(RESET_CYCLES + 100);
    n = cyc;
    expectEvent(n + 3, S_STAB, 0, 0);
    expectEvent(n + RELEASE, S_RUN, 0, 0);
    applyStimulus(1'b1, 1'b0);
    step(RELEASE);
    checkOutput("release_sysrst", int'(sys_rst), 0);
    checkOutput("release_ready", int'(ready), 1);
    checkOutput("release_retry", int'(retry_count), 0);
    step(5);

    // Lock drops for 5 cycles in RUN, then a full relock.
    m = cyc;
    expectEvent(m + 3, S_RST, 1, 0);
    expectEvent(m + 3 + RESET_CYCLES, S_WAIT, 1, 0);
    expectEvent(m + 4 + RESET_CYCLES, S_STAB, 1, 0);
    expectEvent(m + 4 + RESET_CYCLES + STABLE_CYCLES, S_RUN, 1, 0);
    applyStimulus(1'b0, 1'b0);
    step(3);
    checkOutput("drop_sysrst", int'(sys_rst), 1);
    checkOutput("drop_ready", int'(ready), 0);
    checkOutput("drop_lost", int'(lock_lost), 1);
    checkOutput("drop_resetb", int'(pll_resetb), 0);
    step(2);
    applyStimulus(1'b1, 1'b0);
    step(280);
    checkOutput("relock_lost_sticky", int'(lock_lost), 1);

    // One-cycle glitch at STABLE cycle 200.
    p = cyc;
    expectEvent(p + 3, S_RST, 1, 0);
    expectEvent(p + 3 + RESET_CYCLES, S_WAIT, 1, 0);
    expectEvent(p + 4 + RESET_CYCLES, S_STAB, 1, 0);
    applyStimulus(1'b0, 1'b0);
    step(5);
    applyStimulus(1'b1, 1'b0);
    step(215);
    g = cyc;
    expectEvent(g + 3, S_WAIT, 1, 0);
    expectEvent(g + 4, S_STAB, 1, 0);
    expectEvent(g + 1 + RELEASE, S_RUN, 1, 0);
    applyStimulus(1'b0, 1'b0);
    step(1);
    applyStimulus(1'b1, 1'b0);
    step(RELEASE + 5);
    checkOutput("glitch_retry", int'(retry_count), 0);
    checkOutput("glitch_ready", int'(ready), 1);

    // Async reset from RUN, then again mid-WAIT_LOCK.
    q = cyc;
    expectEvent(q, S_RST, 0, 0);
    applyStimulus(1'b0, 1'b1);
    #1 checkResetOutputs("rst_run");
    step(2);
    b2 = cyc;
    applyStimulus(1'b0, 1'b0);
    expectEvent(b2 + RESET_CYCLES, S_WAIT, 0, 0);
    step(RESET_CYCLES + 50);
    q = cyc;
    expectEvent(q, S_RST, 0, 0);
    applyStimulus(1'b0, 1'b1);
    #1 checkResetOutputs("rst_wait");
    step(3);
    b3 = cyc;
    applyStimulus(1'b0, 1'b0);

    // Lock only on the third attempt.
    expectEvent(b3 + RESET_CYCLES, S_WAIT, 0, 0);
    expectEvent(b3 + ATTEMPT, S_RST, 0, 1);
    expectEvent(b3 + ATTEMPT + RESET_CYCLES, S_WAIT, 0, 1);
    expectEvent(b3 + 2 * ATTEMPT, S_RST, 0, 2);
    expectEvent(b3 + 2 * ATTEMPT + RESET_CYCLES, S_WAIT, 0, 2);
    step(2 * ATTEMPT + RESET_CYCLES + 10);
    l = cyc;
    expectEvent(l + 3, S_STAB, 0, 2);
    expectEvent(l + RELEASE, S_RUN, 0, 2);
    applyStimulus(1'b1, 1'b0);
    step(RELEASE + 5);
    checkOutput("third_retry", int'(retry_count), 2);
    checkOutput("third_ready", int'(ready), 1);

    // Lock never arrives: four attempts then FAIL.
    q = cyc;
    expectEvent(q, S_RST, 0, 0);
    applyStimulus(1'b0, 1'b1);
    #1 checkResetOutputs("rst_run2");
    step(2);
    b4 = cyc;
    applyStimulus(1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      expectEvent(b4 + RESET_CYCLES + k * ATTEMPT, S_WAIT, 0, k);
      if (k < 3) expectEvent(b4 + (k + 1) * ATTEMPT, S_RST, 0, k + 1);
    end
    expectEvent(b4 + 4 * ATTEMPT, S_FAIL, 0, 3);
    step(4 * ATTEMPT + 10);
    checkOutput("fail_fail", int'(fail), 1);
    checkOutput("fail_bypass", int'(pll_bypass), 1);
    checkOutput("fail_sysrst", int'(sys_rst), 0);
    checkOutput("fail_retry", int'(retry_count), 3);

    // Lock is ignored in FAIL.
    applyStimulus(1'b1, 1'b0);
    step(20);
    checkOutput("fail_ignores_lock", int'(state), S_FAIL);

    // Async reset out of FAIL, then a clean restart with lock already high.
    q = cyc;
    expectEvent(q, S_RST, 0, 0);
    applyStimulus(1'b1, 1'b1);
    #1 checkResetOutputs("rst_fail");
    step(2);
    b5 = cyc;
    applyStimulus(1'b1, 1'b0);
    expectEvent(b5 + RESET_CYCLES, S_WAIT, 0, 0);
    expectEvent(b5 + RESET_CYCLES + 1, S_STAB, 0, 0);
    expectEvent(b5 + RESET_CYCLES + 1 + STABLE_CYCLES, S_RUN, 0, 0);
    step(RESET_CYCLES + 1 + STABLE_CYCLES + 5);
    checkOutput("sb_drained", sb.size(), 0);

    // Instance without bypass, lock tied low since the first release.
    checkOutput("nobypass_state", int'(state2), S_FAIL);
    checkOutput("nobypass_fail", int'(fail2), 1);
    checkOutput("nobypass_bypass", int'(pll_bypass2), 0);
    checkOutput("nobypass_sysrst", int'(sys_rst2), 1);
    checkOutput("nobypass_resetb", int'(pll_resetb2), 0);
    checkOutput("nobypass_ready", int'(ready2), 0);
    checkOutput("nobypass_retry", int'(retry_count2), 3);
    checkOutput("nobypass_lost", int'(lock_lost2), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
